// File: rtl/fg_sram_arbiter.sv
// Foreground SRAM arbiter: fixed-latency pixel fetch for the display pipeline,
// with capture writes buffered in a FIFO and drained only in read-free cycles.
module fg_sram_arbiter #(
  parameter int PIXEL_SIZE   = 16,
  parameter int PRECISION    = 11,
  parameter int RESOLUTION_X = 800,
  parameter int RESOLUTION_Y = 600,
  parameter int ADDR_WIDTH   = 19,
  parameter int SRAM_LATENCY = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_req_active,
  input  logic signed [PRECISION:0]     rd_req_x,
  input  logic signed [PRECISION:0]     rd_req_y,
  output logic [PIXEL_SIZE-1:0]         rd_pixel,
  output logic                          rd_pixel_skip,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [PRECISION-1:0]          wr_x,
  input  logic [PRECISION-1:0]          wr_y,
  input  logic [PIXEL_SIZE-1:0]         wr_pixel,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [PIXEL_SIZE-1:0]         sram_wdata,
  output logic                          sram_re,
  output logic                          sram_we,
  input  logic [PIXEL_SIZE-1:0]         sram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RES_X_U = RESOLUTION_X;
  localparam logic [31:0] RES_Y_U = RESOLUTION_Y;

  logic [PRECISION-1:0]  rx_mag, ry_mag;
  logic                  rd_inb, wr_inb, full, push, pop;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [SRAM_LATENCY:0] rd_vld;
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [PIXEL_SIZE-1:0] fifo_pix  [FIFO_DEPTH];

  // Read classification, address generation and write acceptance.
  always_comb begin
    rx_mag  = rd_req_x[PRECISION-1:0];
    ry_mag  = rd_req_y[PRECISION-1:0];
    rd_inb  = rd_req_active && !rd_req_x[PRECISION] && !rd_req_y[PRECISION] &&
              (32'(rx_mag) < RES_X_U) && (32'(ry_mag) < RES_Y_U);
    rd_addr = ADDR_WIDTH'(ry_mag) * ADDR_WIDTH'(RES_X_U) + ADDR_WIDTH'(rx_mag);
    wr_inb  = (32'(wr_x) < RES_X_U) && (32'(wr_y) < RES_Y_U);
    wr_addr = ADDR_WIDTH'(wr_y) * ADDR_WIDTH'(RES_X_U) + ADDR_WIDTH'(wr_x);
    full     = (fifo_level == LVL_W'(FIFO_DEPTH));
    wr_ready = !full && !rst;
    // Out-of-bounds writes are consumed by the handshake but never enqueued.
    push     = wr_valid && wr_ready && wr_inb;
    // Pop is gated on the registered level, so it only sees pre-existing entries.
    pop      = !rd_inb && (fifo_level != '0);
  end

  // FIFO storage; contents need no reset since pointers/level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_pix[wr_ptr]  <= wr_pixel;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // SRAM port: reads win the slot; writes drain in free slots; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_re    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_re <= rd_inb;
      sram_we <= pop;
      if (rd_inb) begin
        sram_addr <= rd_addr;
      end else if (pop) begin
        sram_addr  <= fifo_addr[rd_ptr];
        sram_wdata <= fifo_pix[rd_ptr];
      end
    end
  end

  // Per-cycle valid shift register tracking each fetch through the SRAM latency.
  always_ff @(posedge clk) begin
    if (rst) rd_vld <= '0;
    else     rd_vld <= (rd_vld << 1) | (SRAM_LATENCY + 1)'(rd_inb);
  end

  // Output register: capture SRAM data for valid fetches, otherwise signal skip.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pixel      <= '0;
      rd_pixel_skip <= 1'b1;
    end else if (rd_vld[SRAM_LATENCY]) begin
      rd_pixel      <= sram_rdata;
      rd_pixel_skip <= 1'b0;
    end else begin
      rd_pixel      <= '0;
      rd_pixel_skip <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fg_sram_arbiter.sv
// Directed and randomized bench for fg_sram_arbiter at default parameters.
module tb_fg_sram_arbiter;
  localparam int PS = 16;
  localparam int PR = 11;
  localparam int AW = 19;

  logic clk = 1'b0;
  logic rst;
  logic rd_req_active;
  logic signed [PR:0] rd_req_x, rd_req_y;
  logic [PS-1:0] rd_pixel;
  logic rd_pixel_skip;
  logic wr_valid, wr_ready;
  logic [PR-1:0] wr_x, wr_y;
  logic [PS-1:0] wr_pixel, sram_wdata, sram_rdata, drv_rdata, model_rdata;
  logic [AW-1:0] sram_addr;
  logic sram_re, sram_we;
  logic [3:0] fifo_level;
  logic use_model;

  int checks = 0;
  int errors = 0;

  logic [PS-1:0] smem [0:(1<<AW)-1];
  bit            swr  [0:(1<<AW)-1];
  logic [PS-1:0] rmem [int];

  always #5 clk = ~clk;

  assign sram_rdata = use_model ? model_rdata : drv_rdata;

  // SRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (sram_we) begin
      smem[sram_addr] <= sram_wdata;
      swr[sram_addr]  <= 1'b1;
    end
    if (sram_re) model_rdata <= smem[sram_addr];
  end

  fg_sram_arbiter #(
    .PIXEL_SIZE(16), .PRECISION(11), .RESOLUTION_X(800), .RESOLUTION_Y(600),
    .ADDR_WIDTH(19), .SRAM_LATENCY(1), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req_active(rd_req_active), .rd_req_x(rd_req_x), .rd_req_y(rd_req_y),
    .rd_pixel(rd_pixel), .rd_pixel_skip(rd_pixel_skip),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_re(sram_re), .sram_we(sram_we),
    .sram_rdata(sram_rdata), .fifo_level(fifo_level)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rd_req_active = 1'b0; rd_req_x = '0; rd_req_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_pixel = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; use_model = 1'b0; drv_rdata = '0;
    idle();
    step(); step();
    checks++; if (rd_pixel !== 16'h0) begin errors++; $display("FAIL reset_pixel got %h want 0000", rd_pixel); end
    checks++; if (rd_pixel_skip !== 1'b1) begin errors++; $display("FAIL reset_skip got %b want 1", rd_pixel_skip); end
    checks++; if (sram_re !== 1'b0 || sram_we !== 1'b0) begin errors++; $display("FAIL reset_strobes got re=%b we=%b want 0 0", sram_re, sram_we); end
    checks++; if (sram_addr !== '0 || sram_wdata !== '0) begin errors++; $display("FAIL reset_addr_data got %h %h want 0 0", sram_addr, sram_wdata); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read;
    rd_req_active = 1'b1; rd_req_x = 12'sd5; rd_req_y = 12'sd2;
    step();
    idle(); drv_rdata = 16'h1111;
    checks++; if (sram_re !== 1'b1 || sram_we !== 1'b0) begin errors++; $display("FAIL read_strobe got re=%b we=%b want 1 0", sram_re, sram_we); end
    checks++; if (sram_addr !== 19'd1605) begin errors++; $display("FAIL read_addr got %0d want 1605", sram_addr); end
    step();
    drv_rdata = 16'hABCD;
    checks++; if (rd_pixel_skip !== 1'b1) begin errors++; $display("FAIL read_early_skip got %b want 1", rd_pixel_skip); end
    step();
    drv_rdata = 16'h0;
    checks++; if (rd_pixel !== 16'hABCD || rd_pixel_skip !== 1'b0) begin errors++; $display("FAIL read_data got %h skip=%b want abcd skip=0", rd_pixel, rd_pixel_skip); end
    step();
    checks++; if (rd_pixel_skip !== 1'b1 || rd_pixel !== 16'h0) begin errors++; $display("FAIL read_after got %h skip=%b want 0000 skip=1", rd_pixel, rd_pixel_skip); end
  endtask

  task automatic test_oob_read;
    rd_req_active = 1'b1; rd_req_x = 12'sd0; rd_req_y = 12'sd0;
    wr_valid = 1'b1; wr_x = 11'd3; wr_y = 11'd1; wr_pixel = 16'h1234;
    step();
    wr_valid = 1'b0;
    rd_req_active = 1'b1; rd_req_x = -12'sd1; rd_req_y = 12'sd0;
    step();
    idle(); drv_rdata = 16'h5555;
    checks++; if (sram_re !== 1'b0 || sram_we !== 1'b1) begin errors++; $display("FAIL oob_strobes got re=%b we=%b want 0 1", sram_re, sram_we); end
    checks++; if (sram_addr !== 19'd803 || sram_wdata !== 16'h1234) begin errors++; $display("FAIL oob_write got %0d %h want 803 1234", sram_addr, sram_wdata); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL oob_level got %0d want 0", fifo_level); end
    step(); step();
    drv_rdata = 16'h0;
    checks++; if (rd_pixel !== 16'h0 || rd_pixel_skip !== 1'b1) begin errors++; $display("FAIL oob_result got %h skip=%b want 0000 skip=1", rd_pixel, rd_pixel_skip); end
  endtask

  task automatic test_fifo_full;
    rd_req_active = 1'b1; rd_req_x = 12'sd1; rd_req_y = 12'sd1;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1; wr_x = 11'(i); wr_y = 11'd0; wr_pixel = 16'(16'h0100 + i);
      checks++; if (wr_ready !== (i < 8)) begin errors++; $display("FAIL full_ready[%0d] got %b want %b", i, wr_ready, (i < 8)); end
      step();
      checks++; if (sram_we !== 1'b0) begin errors++; $display("FAIL full_no_we[%0d] got %b want 0", i, sram_we); end
    end
    wr_valid = 1'b0;
    checks++; if (fifo_level !== 4'd8 || wr_ready !== 1'b0) begin errors++; $display("FAIL full_level got %0d ready=%b want 8 ready=0", fifo_level, wr_ready); end
    rd_req_active = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      checks++;
      if (sram_we !== 1'b1 || sram_addr !== 19'(j) || sram_wdata !== 16'(16'h0100 + j)) begin
        errors++; $display("FAIL drain[%0d] got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", j, sram_we, sram_addr, sram_wdata, j, 16'(16'h0100 + j));
      end
    end
    step();
    checks++; if (sram_we !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL drain_end got we=%b level=%0d want 0 0", sram_we, fifo_level); end
  endtask

  task automatic test_boundary;
    idle();
    wr_valid = 1'b1; wr_x = 11'd799; wr_y = 11'd599; wr_pixel = 16'hBEEF;
    step();
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL corner_level got %0d want 1", fifo_level); end
    wr_x = 11'd800; wr_y = 11'd0; wr_pixel = 16'hDEAD;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oob_wr_ready got %b want 1", wr_ready); end
    step();
    wr_valid = 1'b0;
    checks++; if (sram_we !== 1'b1 || sram_addr !== 19'd479999 || sram_wdata !== 16'hBEEF) begin errors++; $display("FAIL corner_write got we=%b addr=%0d data=%h want 1 479999 beef", sram_we, sram_addr, sram_wdata); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL oob_wr_level got %0d want 0", fifo_level); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (sram_we !== 1'b0) begin errors++; $display("FAIL oob_wr_written[%0d] got we=%b addr=%0d want we=0", i, sram_we, sram_addr); end
    end
  endtask

  task automatic test_reset_flight;
    rd_req_active = 1'b1; rd_req_x = 12'sd2; rd_req_y = 12'sd3;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_x = 11'(10 + i); wr_y = 11'd5; wr_pixel = 16'(16'h0A00 + i);
      step();
    end
    wr_valid = 1'b0;
    step();
    checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL flight_level got %0d want 3", fifo_level); end
    rst = 1'b1; idle(); drv_rdata = 16'h7777;
    step();
    checks++; if (rd_pixel !== 16'h0 || rd_pixel_skip !== 1'b1) begin errors++; $display("FAIL rst_out got %h skip=%b want 0000 skip=1", rd_pixel, rd_pixel_skip); end
    checks++; if (sram_re !== 1'b0 || sram_we !== 1'b0 || sram_addr !== '0 || sram_wdata !== '0) begin errors++; $display("FAIL rst_sram got re=%b we=%b addr=%0d data=%h want all 0", sram_re, sram_we, sram_addr, sram_wdata); end
    checks++; if (fifo_level !== 4'd0 || wr_ready !== 1'b0) begin errors++; $display("FAIL rst_fifo got level=%0d ready=%b want 0 0", fifo_level, wr_ready); end
    rst = 1'b0;
    step();
    checks++; if (rd_pixel !== 16'h0 || rd_pixel_skip !== 1'b1) begin errors++; $display("FAIL flight_skip got %h skip=%b want 0000 skip=1", rd_pixel, rd_pixel_skip); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (sram_we !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL post_rst_we[%0d] got we=%b level=%0d want 0 0", i, sram_we, fifo_level); end
    end
    drv_rdata = 16'h0;
  endtask

  task automatic test_random;
    use_model = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      rd_req_active = 1'($urandom_range(0, 1));
      rd_req_x = 12'(int'($urandom_range(0, 11)) - 2);
      rd_req_y = 12'(int'($urandom_range(0, 5)) - 1);
      wr_valid = 1'($urandom_range(0, 1));
      wr_x = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(796, 803)) : 11'($urandom_range(0, 7));
      wr_y = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(596, 603)) : 11'($urandom_range(0, 3));
      wr_pixel = 16'($urandom);
      if (wr_valid && wr_ready && wr_x < 11'd800 && wr_y < 11'd600)
        rmem[int'(wr_y) * 800 + int'(wr_x)] = wr_pixel;
      step();
      checks++; if (sram_re && sram_we) begin errors++; $display("FAIL rand_mutex[%0d] got re=%b we=%b want not both", c, sram_re, sram_we); end
    end
    idle();
    for (int t = 0; t < 50 && fifo_level != 4'd0; t++) step();
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rand_drain got level=%0d want 0", fifo_level); end
    step(); step();
    foreach (rmem[k]) begin
      checks++;
      if (!swr[k] || smem[k] !== rmem[k]) begin errors++; $display("FAIL rand_mem[%0d] got %h written=%b want %h", k, smem[k], swr[k], rmem[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_oob_read();
    test_fifo_full();
    test_boundary();
    test_reset_flight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fg_sram_arbiter.md
FG_SRAM_ARBITER -- requirements
Module: fg_sram_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- PIXEL_SIZE, 16, bits per RGB565 pixel.
- PRECISION, 11, coordinate width.
- RESOLUTION_X, 800, foreground frame width.
- RESOLUTION_Y, 600, foreground frame height.
- ADDR_WIDTH, 19, SRAM word address width.
- SRAM_LATENCY, 1, cycles from address presented to sram_rdata valid.
- FIFO_DEPTH, 8, write FIFO entries (power of two).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- rd_req_active  in  1  pipeline foreground fetch request.
- rd_req_x  in  PRECISION+1 signed  fetch x.
- rd_req_y  in  PRECISION+1 signed  fetch y.
- rd_pixel  out  PIXEL_SIZE  fetched pixel.
- rd_pixel_skip  out  1  fetch result invalid; pipeline shows background.
- wr_valid  in  1  capture write offered.
- wr_ready  out  1  write accepted this cycle.
- wr_x  in  PRECISION  write x.
- wr_y  in  PRECISION  write y.
- wr_pixel  in  PIXEL_SIZE  write data.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_wdata  out  PIXEL_SIZE  SRAM write data.
- sram_re  out  1  SRAM read strobe.
- sram_we  out  1  SRAM write strobe.
- sram_rdata  in  PIXEL_SIZE  SRAM read data.
- fifo_level  out  clog2(FIFO_DEPTH)+1  write FIFO occupancy.
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 SHALL compute address = y*RESOLUTION_X + x, truncated to ADDR_WIDTH.
REQ-005 SHALL classify a read as in-bounds iff rd_req_active=1, 0<=x<RESOLUTION_X and 0<=y<RESOLUTION_Y.
REQ-006 SHALL, for an in-bounds read sampled in cycle N, drive sram_re=1 and sram_addr in cycle N+1 (registered).
REQ-007 SHALL register sram_rdata in cycle N+1+SRAM_LATENCY, so rd_pixel is valid in cycle N+2+SRAM_LATENCY (fixed latency, 3 at default), with rd_pixel_skip=0.
REQ-008 SHALL, for an out-of-bounds or inactive read, issue no SRAM read; the same fixed latency later it SHALL output rd_pixel=0 and rd_pixel_skip=1.
REQ-009 SHALL carry a per-cycle valid/skip shift register; reads are never stalled or dropped and are accepted every cycle.
REQ-010 SHALL accept a write when wr_valid && wr_ready; wr_ready = !full && !rst.
REQ-011 SHALL discard accepted writes whose wr_x>=RESOLUTION_X or wr_y>=RESOLUTION_Y at push: no FIFO entry, fifo_level unchanged.
REQ-012 SHALL store in-bounds writes as {address, pixel} in FIFO order.
REQ-013 SHALL treat cycle N as a free slot when no in-bounds read is sampled in N; a free slot with a non-empty FIFO pops the head and drives sram_we=1, sram_addr and sram_wdata in N+1.
REQ-014 SHALL give reads strict priority; writes wait indefinitely under continuous in-bounds reads.
REQ-015 SHALL never assert sram_re and sram_we in the same cycle; with neither asserted, sram_addr and sram_wdata hold their values.
REQ-016 SHALL handle a simultaneous push and pop correctly (net level change 0); a pop SHALL use only entries present before that cycle.
REQ-017 SHALL update fifo_level registered, in the cycle after a push or pop.

Reset
REQ-018 SHALL, while rst=1, set rd_pixel=0, rd_pixel_skip=1, sram_re=0, sram_we=0, sram_addr=0, sram_wdata=0, fifo_level=0 and wr_ready=0, and clear the FIFO and the valid/skip pipeline.
REQ-019 SHALL return rd_pixel_skip=1 for reads in flight when rst is asserted; no pre-reset FIFO entry is ever written to SRAM.

Verification
REQ-020 SHALL cover: read (5,2) active in cycle N -> sram_re=1, sram_addr=1605 in N+1; sram_rdata=0xABCD in N+2 -> rd_pixel=0xABCD, skip=0 in N+3.
REQ-021 SHALL cover: read x=-1 with one FIFO entry pending -> no sram_re; sram_we in N+1; rd_pixel=0, skip=1 in N+3.
REQ-022 SHALL cover: 9 writes offered under continuous in-bounds reads -> 8 accepted, fifo_level=8, wr_ready=0, no sram_we; reads stop -> 8 consecutive sram_we in push order.
REQ-023 SHALL cover: write (799,599) -> sram_addr=479999 with sram_we; write (800,0) -> accepted, fifo_level unchanged, never written.
REQ-024 SHALL cover: 3 FIFO entries plus one read in flight, rst high for 1 cycle -> all outputs at reset values, skip=1 for the in-flight read, no subsequent sram_we.
REQ-025 SHALL cover: random alternating reads and writes over 10000 cycles -> sram_re and sram_we are never both 1, and SRAM contents match the reference model.
